// File: rtl/ds1302_defs.sv
// DS1302 reader shared definitions: command bytes, field masks, FSM encodings.
// Latency: none (constants only); backpressure: not applicable.
package ds1302_defs;

  localparam logic [7:0] SEC_RD   = 8'h81;
  localparam logic [7:0] MIN_RD   = 8'h83;
  localparam logic [7:0] HR_RD    = 8'h85;
  localparam logic [7:0] BURST_RD = 8'hBF;

  localparam logic [7:0] SEC_MASK = 8'h7F;
  localparam logic [7:0] MIN_MASK = 8'h7F;
  localparam logic [7:0] HR_MASK  = 8'h3F;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CE_SETUP = 3'd1;
  localparam logic [2:0] ST_CMD      = 3'd2;
  localparam logic [2:0] ST_READ     = 3'd3;
  localparam logic [2:0] ST_CE_HOLD  = 3'd4;
  localparam logic [2:0] ST_CE_LOW   = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] min;
    logic [7:0] sec;
  } time_bytes_t;

  function automatic logic [7:0] reg_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return SEC_RD;
      2'd1:    return MIN_RD;
      default: return HR_RD;
    endcase
  endfunction

endpackage

// File: rtl/ds1302_sclk_gen.sv
// SCLK generator: HALF-cycle phases, low phase first, with rise/fall/sample strobes.
// Latency: strobes mark the cycle whose closing edge moves SCLK; no backpressure, run=0 parks SCLK low.
module ds1302_sclk_gen #(
  parameter int HALF = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb,
  output logic sample_stb
);

  localparam int CW = $clog2(HALF) + 1;
  localparam logic [CW-1:0] LAST      = CW'(HALF - 1);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(HALF - 1);

  logic [CW-1:0] cnt;
  logic          phase_end;

  assign phase_end  = run && (cnt == LAST);
  assign rise_stb   = phase_end && !sclk;
  assign fall_stb   = phase_end && sclk;
  // Last cycle of the low phase: the slave's bit has settled through the synchroniser.
  assign sample_stb = run && !sclk && (cnt == SAMPLE_AT);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (phase_end) begin
      cnt  <= '0;
      sclk <= !sclk;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ds1302_time_reader.sv
// DS1302 3-wire master reading sec/min/hr into atomic BCD {HH,MM,SS}; DS1302_BURST_EN selects one clock-burst window.
// Latency: three (or one burst) CE windows per req; req ignored while busy, no queueing.
module ds1302_time_reader
  import ds1302_defs::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCLK_HZ  = 500_000,
  parameter int CE_GUARD = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        busy,
  output logic [23:0] time_bcd,
  output logic        time_valid,
  output logic        rtc_ce,
  output logic        rtc_sclk,
  output logic        rtc_io_out,
  output logic        rtc_io_oe,
  input  logic        rtc_io_in
);

  localparam int HALF = CLK_HZ / (2 * SCLK_HZ);
  localparam int GW   = $clog2(CE_GUARD) + 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(CE_GUARD - 1);

`ifdef DS1302_BURST_EN
  localparam int         RX_W     = 24;
  localparam logic [4:0] RD_BITS  = 5'd24;
  localparam logic [1:0] LAST_REG = 2'd0;
`else
  localparam int         RX_W     = 8;
  localparam logic [4:0] RD_BITS  = 5'd8;
  localparam logic [1:0] LAST_REG = 2'd2;
`endif

  logic [2:0]      state;
  logic [GW-1:0]   guard_cnt;
  logic [4:0]      bit_cnt;
  logic [1:0]      reg_idx;
  logic [6:0]      cmd_sh;
  logic [RX_W-1:0] rx_sh;
  logic [1:0]      io_sync;
  logic [7:0]      cur_cmd;
  time_bytes_t     shadow;
  logic            sclk_run, rise_stb, fall_stb, sample_stb, guard_done;

`ifdef DS1302_BURST_EN
  assign cur_cmd = BURST_RD;
`else
  assign cur_cmd = reg_cmd(reg_idx);
`endif

  assign sclk_run   = (state == ST_CMD) || (state == ST_READ);
  assign guard_done = (guard_cnt == GUARD_LAST);
  assign busy       = (state != ST_IDLE);
  assign time_valid = (state == ST_DONE);

  ds1302_sclk_gen #(.HALF(HALF)) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (sclk_run),
    .sclk       (rtc_sclk),
    .rise_stb   (rise_stb),
    .fall_stb   (fall_stb),
    .sample_stb (sample_stb)
  );

  always_ff @(posedge clk) begin
    if (rst) io_sync <= 2'b00;
    else     io_sync <= {io_sync[0], rtc_io_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      guard_cnt  <= '0;
      bit_cnt    <= '0;
      reg_idx    <= '0;
      cmd_sh     <= '0;
      rx_sh      <= '0;
      shadow     <= '0;
      time_bcd   <= '0;
      rtc_ce     <= 1'b0;
      rtc_io_out <= 1'b0;
      rtc_io_oe  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          state     <= ST_CE_SETUP;
          rtc_ce    <= 1'b1;
          guard_cnt <= '0;
          reg_idx   <= '0;
        end
        ST_CE_SETUP: begin
          if (guard_done) begin
            state      <= ST_CMD;
            bit_cnt    <= '0;
            cmd_sh     <= cur_cmd[7:1];
            rtc_io_out <= cur_cmd[0];
            rtc_io_oe  <= 1'b1;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        ST_CMD: begin
          if (rise_stb) bit_cnt <= bit_cnt + 5'd1;
          // Next command bit goes out on the falling edge so it is stable over the low phase.
          if (fall_stb) begin
            if (bit_cnt == 5'd8) begin
              state      <= ST_READ;
              bit_cnt    <= '0;
              rtc_io_oe  <= 1'b0;
              rtc_io_out <= 1'b0;
            end else begin
              rtc_io_out <= cmd_sh[0];
              cmd_sh     <= {1'b0, cmd_sh[6:1]};
            end
          end
        end
        ST_READ: begin
          if (rise_stb)   bit_cnt <= bit_cnt + 5'd1;
          if (sample_stb) rx_sh   <= {io_sync[1], rx_sh[RX_W-1:1]};
          if (fall_stb && bit_cnt == RD_BITS) begin
            state     <= ST_CE_HOLD;
            guard_cnt <= '0;
`ifdef DS1302_BURST_EN
            shadow <= time_bytes_t'(rx_sh);
`else
            case (reg_idx)
              2'd0:    shadow.sec <= rx_sh;
              2'd1:    shadow.min <= rx_sh;
              default: shadow.hr  <= rx_sh;
            endcase
`endif
          end
        end
        ST_CE_HOLD: begin
          if (guard_done) begin
            state     <= ST_CE_LOW;
            rtc_ce    <= 1'b0;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        ST_CE_LOW: begin
          if (guard_done) begin
            guard_cnt <= '0;
            if (reg_idx == LAST_REG) begin
              state    <= ST_DONE;
              time_bcd <= {shadow.hr & HR_MASK, shadow.min & MIN_MASK, shadow.sec & SEC_MASK};
            end else begin
              state   <= ST_CE_SETUP;
              rtc_ce  <= 1'b1;
              reg_idx <= reg_idx + 2'd1;
            end
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ds1302_time_reader.sv
// Bench for ds1302_time_reader: behavioural DS1302 slave, randomised register data.
// Latency/backpressure: driven at negedge, outputs sampled at negedge.
module tb_ds1302_time_reader;

  localparam int CLK_HZ   = 8;
  localparam int SCLK_HZ  = 1;
  localparam int CE_GUARD = 10;
  localparam int PERIOD   = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        busy, time_valid;
  logic [23:0] time_bcd;
  logic        rtc_ce, rtc_sclk, rtc_io_out, rtc_io_oe;
  logic        io_drv = 1'b0;

  always #(PERIOD/2) clk = ~clk;

  ds1302_time_reader #(
    .CLK_HZ   (CLK_HZ),
    .SCLK_HZ  (SCLK_HZ),
    .CE_GUARD (CE_GUARD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .busy       (busy),
    .time_bcd   (time_bcd),
    .time_valid (time_valid),
    .rtc_ce     (rtc_ce),
    .rtc_sclk   (rtc_sclk),
    .rtc_io_out (rtc_io_out),
    .rtc_io_oe  (rtc_io_oe),
    .rtc_io_in  (io_drv)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: register contents and what it observed on the bus
  logic [7:0] m_sec, m_min, m_hr, m_cmd;
  logic [7:0] cmd_q[$];
  int         sclk_n = 0;
  int         rd_clocks = 0;
  int         oe_bad = 0;
  int         min_setup = 1_000_000;
  int         tv_cnt = 0;
  int         setup_cyc;
  time        ce_t = 0;

  function automatic logic read_bit(input logic [7:0] cmd, input int k);
    logic [23:0] stream;
    case (cmd)
      8'hBF:   stream = {m_hr, m_min, m_sec};
      8'h81:   stream = {16'h0, m_sec};
      8'h83:   stream = {16'h0, m_min};
      8'h85:   stream = {16'h0, m_hr};
      default: stream = 24'h0;
    endcase
    return (k < 24) ? stream[k] : 1'b0;
  endfunction

  function automatic logic [23:0] exp_time(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    return {2'b00, h[5:0], 1'b0, m[6:0], 1'b0, s[6:0]};
  endfunction

  always @(posedge rtc_ce) begin
    sclk_n = 0;
    ce_t   = $time;
  end

  always @(posedge rtc_sclk) begin
    if (rtc_ce) begin
      if (sclk_n == 0) begin
        setup_cyc = int'(($time - ce_t) / PERIOD);
        if (setup_cyc < min_setup) min_setup = setup_cyc;
      end
      if (sclk_n < 8) begin
        m_cmd[sclk_n] = rtc_io_out;
        if (!rtc_io_oe) oe_bad++;
        if (sclk_n == 7) cmd_q.push_back(m_cmd);
      end else begin
        rd_clocks++;
        if (rtc_io_oe) oe_bad++;
      end
      sclk_n++;
    end
  end

  always @(negedge rtc_sclk) begin
    if (rtc_ce && sclk_n >= 8) io_drv = read_bit(m_cmd, sclk_n - 8);
  end

  always @(posedge clk) if (time_valid === 1'b1) tv_cnt++;

  task automatic load_model(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    m_sec = s; m_min = m; m_hr = h;
    cmd_q.delete();
    rd_clocks = 0;
    oe_bad    = 0;
    min_setup = 1_000_000;
  endtask

  task automatic wait_valid(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (time_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_cmds(input string tag);
    logic [7:0] exp_q[$];
`ifdef DS1302_BURST_EN
    exp_q = '{8'hBF};
`else
    exp_q = '{8'h81, 8'h83, 8'h85};
`endif
    check_eq({tag, "_ncmd"}, cmd_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("%s_cmd%0d", tag, i), (i < cmd_q.size()) ? cmd_q[i] : 8'h00, exp_q[i]);
  endtask

  task automatic run_read(input string tag, input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    bit ok;
    int tv0;
    load_model(s, m, h);
    tv0 = tv_cnt;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    check_eq({tag, "_busy_start"}, busy, 1);
    wait_valid(tag, ok);
    if (ok) begin
      check_eq({tag, "_time"}, time_bcd, exp_time(s, m, h));
      check_eq({tag, "_busy_valid"}, busy, 1);
      @(negedge clk);
      check_eq({tag, "_busy_after"}, busy, 0);
      check_eq({tag, "_valid_width"}, time_valid, 0);
    end
    repeat (5) @(negedge clk);
    check_eq({tag, "_valid_cnt"}, tv_cnt - tv0, 1);
    check_cmds(tag);
    check_eq({tag, "_rd_clocks"}, rd_clocks, 24);
    check_eq({tag, "_oe_bad"}, oe_bad, 0);
    check_eq({tag, "_ce_setup"}, min_setup >= CE_GUARD, 1);
  endtask

  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int tv0;
    bit hit;

    repeat (3) @(negedge clk);
    check_eq("rst_time", time_bcd, 24'h0);
    check_eq("rst_valid", time_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ce", rtc_ce, 0);
    check_eq("rst_sclk", rtc_sclk, 0);
    check_eq("rst_oe", rtc_io_oe, 0);
    check_eq("rst_io", rtc_io_out, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_read("basic", 8'hC5, 8'h59, 8'h23);
    check_eq("basic_literal", time_bcd, 24'h235945);

    run_read("hr12", 8'h07, 8'h30, 8'h92);
    check_eq("hr12_byte", time_bcd[23:16], 8'h12);

    // req held high across the whole transfer and through the valid cycle
    load_model(8'h11, 8'h22, 8'h13);
    tv0 = tv_cnt;
    @(negedge clk); req = 1'b1;
    wait_valid("hold", ok);
    if (ok) check_eq("hold_time", time_bcd, exp_time(8'h11, 8'h22, 8'h13));
    @(negedge clk); req = 1'b0;
    repeat (600) @(negedge clk);
    check_eq("hold_valid_cnt", tv_cnt - tv0, 1);
    check_eq("hold_busy", busy, 0);
    check_cmds("hold");

    // Reset during the 5th read bit of the minutes byte
    load_model(8'hC5, 8'h59, 8'h23);
    tv0 = tv_cnt;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
`ifdef DS1302_BURST_EN
      if (cmd_q.size() == 1 && sclk_n == 20 && rtc_sclk == 1'b0) begin hit = 1'b1; break; end
`else
      if (cmd_q.size() == 2 && sclk_n == 12 && rtc_sclk == 1'b0) begin hit = 1'b1; break; end
`endif
    end
    check_eq("abort_reached", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ce", rtc_ce, 0);
    check_eq("abort_sclk", rtc_sclk, 0);
    check_eq("abort_oe", rtc_io_oe, 0);
    check_eq("abort_time", time_bcd, 24'h0);
    check_eq("abort_busy", busy, 0);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    check_eq("abort_no_valid", tv_cnt - tv0, 0);
    check_eq("abort_time_held", time_bcd, 24'h0);

    run_read("after_abort", 8'hC5, 8'h59, 8'h23);

    for (int r = 0; r < 3; r++) begin
      logic [7:0] s, m, h;
      s = 8'($urandom_range(0, 255));
      m = 8'($urandom_range(0, 255));
      h = 8'($urandom_range(0, 255));
      run_read($sformatf("rand%0d", r), s, m, h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
